frac_baud_tick_gen: RTL and testbench

//  Programmable fractional baud-tick generator for the UART. Produces an oversampling

---
 rtl/frac_baud_tick_gen.sv | 98 +++++++++
 tb/tb_frac_baud_tick_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/frac_baud_tick_gen.sv
// Fractional baud-tick generator: an integer+fractional divisor produces the
// oversampling tick, with bit-rate and mid-bit decodes and an RX phase resync.
module frac_baud_tick_gen #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16,
  parameter int DEF_INT  = 163,
  parameter int DEF_FRAC = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     load,
  input  logic [DIV_W-1:0]         div_int,
  input  logic [FRAC_W-1:0]        div_frac,
  input  logic                     resync,
  output logic                     sample_tick,
  output logic                     mid_tick,
  output logic                     bit_tick,
  output logic [$clog2(OSR)-1:0]   os_cnt
);

  localparam int CW   = DIV_W + 1;
  localparam int OS_W = $clog2(OSR);

  localparam logic [OS_W-1:0]   OS_LAST    = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]   OS_MID     = OS_W'(OSR / 2 - 1);
  localparam logic [DIV_W-1:0]  DEF_INT_V  = DIV_W'(DEF_INT);
  localparam logic [FRAC_W-1:0] DEF_FRAC_V = FRAC_W'(DEF_FRAC);

  // Divisors below 2 would make the terminal count unreachable or degenerate.
  function automatic logic [CW-1:0] clamp_period(input logic [DIV_W-1:0] v);
    if (v < DIV_W'(2)) begin
      clamp_period = CW'(2);
    end else begin
      clamp_period = {1'b0, v};
    end
  endfunction

  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     period_r;
  logic [FRAC_W-1:0] acc_r;
  logic [OS_W-1:0]   os_cnt_r;
  logic [DIV_W-1:0]  pend_int_r;
  logic [FRAC_W-1:0] pend_frac_r;

  logic              term_s;
  logic              sample_s;
  logic [FRAC_W:0]   frac_sum_s;

  // Tick decodes and the fractional accumulator sum (MSB is the carry).
  always_comb begin
    term_s     = (cnt_r == (period_r - CW'(1)));
    sample_s   = en & ~resync & term_s;
    frac_sum_s = {1'b0, acc_r} + {1'b0, pend_frac_r};
  end

  assign sample_tick = sample_s;
  assign bit_tick    = sample_s & (os_cnt_r == OS_LAST);
  assign mid_tick    = sample_s & (os_cnt_r == OS_MID);
  assign os_cnt      = os_cnt_r;

  // Pending divisor capture; applied only at the next wrap or resync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_int_r  <= DEF_INT_V;
      pend_frac_r <= DEF_FRAC_V;
    end else if (load) begin
      pend_int_r  <= div_int;
      pend_frac_r <= div_frac;
    end
  end

  // Period counter, fractional accumulator and sample index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= '0;
      acc_r    <= '0;
      os_cnt_r <= '0;
      period_r <= clamp_period(DEF_INT_V);
    end else if (resync) begin
      cnt_r    <= '0;
      acc_r    <= '0;
      os_cnt_r <= '0;
      period_r <= clamp_period(pend_int_r);
    end else if (en) begin
      if (term_s) begin
        cnt_r    <= '0;
        acc_r    <= frac_sum_s[FRAC_W-1:0];
        period_r <= clamp_period(pend_int_r) + {{(CW-1){1'b0}}, frac_sum_s[FRAC_W]};
        os_cnt_r <= (os_cnt_r == OS_LAST) ? '0 : os_cnt_r + OS_W'(1);
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_frac_baud_tick_gen.sv
// Directed bench for frac_baud_tick_gen: hand-written corner sequences plus a
// table of divisor settings with hand-computed tick spacings.
`timescale 1ns/1ps
module tb_frac_baud_tick_gen;

  localparam int BOUND = 5000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        resync;
  logic        sample_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic [3:0]  os_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] di;
    logic [3:0]  df;
    int          first;
    int          sum16;
  } vec_t;

  vec_t vecs[7];

  frac_baud_tick_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .load        (load),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .resync      (resync),
    .sample_tick (sample_tick),
    .mid_tick    (mid_tick),
    .bit_tick    (bit_tick),
    .os_cnt      (os_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edges from the current cycle until the next cycle showing sample_tick.
  task automatic next_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_tick && n < BOUND);
    if (!sample_tick) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got no tick after %0d cycles, expected a tick", n);
    end
  endtask

  initial begin
    int n;
    int acc;
    int sum;
    int bit_at;
    int mid_at;
    int seen;

    vecs[0] = '{16'd163, 4'd0,  163, 2608};
    vecs[1] = '{16'd162, 4'd12, 162, 2604};
    vecs[2] = '{16'd1,   4'd0,  2,   32};
    vecs[3] = '{16'd0,   4'd5,  2,   37};
    vecs[4] = '{16'd2,   4'd15, 2,   47};
    vecs[5] = '{16'd10,  4'd1,  10,  161};
    vecs[6] = '{16'd7,   4'd8,  7,   120};

    reset_n = 1'b0; en = 1'b1; load = 1'b0; resync = 1'b0;
    div_int = 16'd0; div_frac = 4'd0;

    // T1: defaults 163/0
    step(); step();
    chk("rst_sample", int'(sample_tick), 0);
    chk("rst_bit", int'(bit_tick), 0);
    chk("rst_os", int'(os_cnt), 0);
    reset_n = 1'b1;
    next_tick(n);
    chk("t1_first", n, 162);
    chk("t1_first_os", int'(os_cnt), 0);
    for (int k = 2; k <= 16; k++) begin
      next_tick(n);
      chk("t1_period", n, 163);
      if (k == 8) begin
        chk("t1_mid", int'(mid_tick), 1);
        chk("t1_mid_nobit", int'(bit_tick), 0);
      end
    end
    chk("t1_bit", int'(bit_tick), 1);
    acc = 0;
    for (int k = 0; k < 8; k++) begin next_tick(n); acc += n; end
    chk("t1_bit_to_mid", acc, 1304);
    chk("t1_mid2", int'(mid_tick), 1);
    for (int k = 0; k < 8; k++) begin next_tick(n); acc += n; end
    chk("t1_bit_to_bit", acc, 2608);
    chk("t1_bit2", int'(bit_tick), 1);

    // T3: resync at cnt=50, os_cnt=7
    reset_n = 1'b0; step(); reset_n = 1'b1;
    for (int k = 0; k < 7; k++) next_tick(n);
    step();
    repeat (50) step();
    chk("t3_pre_os", int'(os_cnt), 7);
    resync = 1'b1;
    #1;
    chk("t3_no_tick", int'(sample_tick), 0);
    step();
    resync = 1'b0;
    chk("t3_os_zero", int'(os_cnt), 0);
    next_tick(n);
    chk("t3_after_resync", n, 162);

    // T4: en low for 100 cycles at cnt=80
    step();
    repeat (80) step();
    en = 1'b0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (sample_tick) seen++;
      step();
    end
    chk("t4_no_ticks", seen, 0);
    chk("t4_os_frozen", int'(os_cnt), 1);
    en = 1'b1;
    next_tick(n);
    chk("t4_resume", n, 82);

    // T5: load on a wrap cycle, then clamp of 0/1, then 5 mid-period
    load = 1'b1; div_int = 16'd1; div_frac = 4'd0;
    step();
    div_int = 16'd0;
    step();
    load = 1'b0;
    next_tick(n);
    chk("t5_old_period", n, 161);
    next_tick(n);
    chk("t5_clamp_a", n, 2);
    next_tick(n);
    chk("t5_clamp_b", n, 2);
    step();
    load = 1'b1; div_int = 16'd5;
    step();
    load = 1'b0;
    chk("t5_old_len", int'(sample_tick), 1);
    next_tick(n);
    chk("t5_new_a", n, 5);
    next_tick(n);
    chk("t5_new_b", n, 5);

    // T6: async reset on a tick cycle mid-bit
    for (int k = 0; k < 3; k++) next_tick(n);
    reset_n = 1'b0;
    #1;
    chk("t6_tick_drop", int'(sample_tick), 0);
    chk("t6_os_zero", int'(os_cnt), 0);
    step(); step();
    reset_n = 1'b1;
    next_tick(n);
    chk("t6_first", n, 162);
    next_tick(n);
    chk("t6_period", n, 163);

    // Table: load, resync, then the first period and the next 16 periods
    foreach (vecs[i]) begin
      div_int = vecs[i].di; div_frac = vecs[i].df; load = 1'b1;
      step();
      load = 1'b0; resync = 1'b1;
      step();
      resync = 1'b0;
      next_tick(n);
      chk($sformatf("vec%0d_first", i), n + 1, vecs[i].first);
      sum = 0; bit_at = 0; mid_at = 0;
      for (int k = 2; k <= 17; k++) begin
        next_tick(n);
        sum += n;
        if (bit_tick && bit_at == 0) bit_at = k;
        if (mid_tick && mid_at == 0) mid_at = k;
      end
      chk($sformatf("vec%0d_sum16", i), sum, vecs[i].sum16);
      chk($sformatf("vec%0d_bit_idx", i), bit_at, 16);
      chk($sformatf("vec%0d_mid_idx", i), mid_at, 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
